// File: rtl/lfu_slot_mgr.sv
// LFU slot manager: N request channels share CAPACITY slots; on a full miss the least-used slot is evicted.
// Optional count decay every 2**AGE_SHIFT ticks is built when LFU_AGING_EN is defined.
module lfu_slot_mgr #(
   parameter  int N         = 4,
   parameter  int CAPACITY  = 3,
   parameter  int CNT_W     = 4,
   parameter  int AGE_SHIFT = 3,
   localparam int IW        = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  active,
   output logic          full,
   output logic          evict_valid,
   output logic [IW-1:0] evict_idx
);

   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   if (N < 2 || N > 32 || CAPACITY < 1 || CAPACITY >= N ||
       CNT_W < 1 || AGE_SHIFT < 0) begin : g_bad_cfg
      $error("lfu_slot_mgr: illegal parameter set");
   end

   logic [CNT_W-1:0] cnt_q    [N];
   logic [CNT_W-1:0] cnt_base [N];
   logic [CNT_W-1:0] cnt_inc  [N];
   logic [CNT_W-1:0] cnt_d    [N];

   logic [N-1:0]     active_d;
   logic             full_d;
   logic             ev_d;
   logic [IW-1:0]    idx_d;

   logic             cand_found;
   logic [IW-1:0]    cand;
   logic             vic_found;
   logic [IW-1:0]    vic;
   logic [CNT_W-1:0] vic_cnt;
   logic [IW:0]      pop;

`ifdef LFU_AGING_EN
   localparam int AW         = AGE_SHIFT + 1;
   localparam int AGE_PERIOD = 2 ** AGE_SHIFT;

   logic [AW-1:0] age_q;
   logic [AW-1:0] age_d;
   logic          age_fire;

   always_comb begin
      age_fire = (age_q == AW'(AGE_PERIOD - 1));
      age_d    = age_fire ? '0 : age_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= '0;
      end else if (tick) begin
         age_q <= age_d;
      end
   end
`endif

   // Decay (if built) comes first, then saturating usage increment.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_base[i] = cnt_q[i];
`ifdef LFU_AGING_EN
         if (age_fire) begin
            cnt_base[i] = cnt_q[i] >> 1;
         end
`endif
         cnt_inc[i] = cnt_base[i];
         if (req[i] && cnt_base[i] != CMAX) begin
            cnt_inc[i] = cnt_base[i] + CNT_W'(1);
         end
      end
   end

   // Lowest-index requester that does not yet hold a slot.
   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && !active[i]) begin
            cand_found = 1'b1;
            cand       = IW'(i);
         end
      end
   end

   // Strict less-than keeps the lowest index on equal counts.
   always_comb begin
      vic_found = 1'b0;
      vic       = '0;
      vic_cnt   = '0;
      for (int i = 0; i < N; i++) begin
         if (active[i] && (!vic_found || cnt_inc[i] < vic_cnt)) begin
            vic_found = 1'b1;
            vic       = IW'(i);
            vic_cnt   = cnt_inc[i];
         end
      end
   end

   always_comb begin
      active_d = active;
      cnt_d    = cnt_inc;
      ev_d     = 1'b0;
      idx_d    = evict_idx;
      unique case (1'b1)
         (cand_found && !full): begin
            active_d[cand] = 1'b1;
         end
         (cand_found && full): begin
            active_d[vic]  = 1'b0;
            cnt_d[vic]     = '0;
            active_d[cand] = 1'b1;
            ev_d           = 1'b1;
            idx_d          = vic;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) begin
         pop = pop + {{IW{1'b0}}, active_d[i]};
      end
      full_d = (pop == (IW + 1)'(CAPACITY));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active      <= '0;
         full        <= 1'b0;
         evict_valid <= 1'b0;
         evict_idx   <= '0;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (tick) begin
         active      <= active_d;
         full        <= full_d;
         evict_valid <= ev_d;
         evict_idx   <= idx_d;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end else begin
         evict_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lfu_slot_mgr.sv
// Bench for lfu_slot_mgr: reference model feeds a scoreboard queue,
// plus fixed expectations for the key scenarios.
module tb_lfu_slot_mgr;

   localparam int N   = 4;
   localparam int CAP = 3;
   localparam int CW  = 4;
   localparam int AS  = 3;

   logic         clk  = 1'b0;
   logic         rst  = 1'b1;
   logic         tick = 1'b0;
   logic [N-1:0] req  = '0;
   logic [N-1:0] active;
   logic         full;
   logic         evict_valid;
   logic [1:0]   evict_idx;

   always #5 clk = ~clk;

   lfu_slot_mgr #(
      .N(N), .CAPACITY(CAP), .CNT_W(CW), .AGE_SHIFT(AS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .req(req),
      .active(active),
      .full(full),
      .evict_valid(evict_valid),
      .evict_idx(evict_idx)
   );

   typedef struct packed {
      logic [N-1:0] act;
      logic         full;
      logic         ev;
      logic [1:0]   idx;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic [N-1:0] m_act = '0;
   int           m_cnt[N];
   logic         m_ev  = 1'b0;
   logic [1:0]   m_idx = '0;
   int           m_age = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic t,
                        input logic [N-1:0] rq);
      int   cand;
      int   v;
      exp_t e;
      if (r) begin
         m_act = '0;
         m_ev  = 1'b0;
         m_idx = '0;
         m_age = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (!t) begin
         m_ev = 1'b0;
      end else begin
`ifdef LFU_AGING_EN
         if (m_age == (1 << AS) - 1) begin
            m_age = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = m_cnt[i] / 2;
         end else begin
            m_age++;
         end
`endif
         for (int i = 0; i < N; i++)
            if (rq[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
         cand = -1;
         for (int i = 0; i < N; i++)
            if (cand < 0 && rq[i] && !m_act[i]) cand = i;
         m_ev = 1'b0;
         if (cand >= 0) begin
            if ($countones(m_act) < CAP) begin
               m_act[cand] = 1'b1;
            end else begin
               v = -1;
               for (int i = 0; i < N; i++)
                  if (m_act[i] && (v < 0 || m_cnt[i] < m_cnt[v])) v = i;
               m_act[v]    = 1'b0;
               m_cnt[v]    = 0;
               m_act[cand] = 1'b1;
               m_ev        = 1'b1;
               m_idx       = 2'(v);
            end
         end
      end
      e.act  = m_act;
      e.full = ($countones(m_act) == CAP);
      e.ev   = m_ev;
      e.idx  = m_idx;
      sb_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic t,
                       input logic [N-1:0] rq);
      exp_t e;
      model(r, t, rq);
      rst  = r;
      tick = t;
      req  = rq;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("sb_active", 32'(active), 32'(e.act));
      chk("sb_full", 32'(full), 32'(e.full));
      chk("sb_evict_valid", 32'(evict_valid), 32'(e.ev));
      chk("sb_evict_idx", 32'(evict_idx), 32'(e.idx));
   endtask

   task automatic ticks(input int n, input logic [N-1:0] rq);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, rq);
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      @(negedge clk);

      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      chk("rst_active", 32'(active), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_ev", 32'(evict_valid), 32'h0);
      chk("rst_idx", 32'(evict_idx), 32'h0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'b0001);
      chk("no_tick_active", 32'(active), 32'h0);

      ticks(1, 4'b0001);
      chk("ins0_active", 32'(active), 32'h1);
      ticks(1, 4'b0010);
      ticks(1, 4'b0100);
      chk("fill_active", 32'(active), 32'h7);
      chk("fill_full", 32'(full), 32'h1);

      ticks(3, 4'b0111);
      ticks(2, 4'b0011);
      ticks(1, 4'b1000);
`ifndef LFU_AGING_EN
      chk("lfu_active", 32'(active), 32'hb);
      chk("lfu_ev", 32'(evict_valid), 32'h1);
      chk("lfu_idx", 32'(evict_idx), 32'h2);
`endif
      step(1'b0, 1'b0, '0);
      chk("ev_pulse_drop", 32'(evict_valid), 32'h0);
      ticks(1, 4'b0100);

      step(1'b1, 1'b0, '0);
      ticks(1, 4'b0001);
      ticks(1, 4'b0010);
      ticks(1, 4'b0100);
      ticks(1, 4'b0111);
      ticks(1, 4'b1000);
      chk("tie_idx", 32'(evict_idx), 32'h0);
      chk("tie_active", 32'(active), 32'he);

      step(1'b1, 1'b0, '0);
      ticks(1, 4'b0001);
      ticks(1, 4'b1100);
      chk("one_ins_active", 32'(active), 32'h5);
      ticks(1, 4'b1100);
      chk("retry_active", 32'(active), 32'hd);
      chk("retry_no_ev", 32'(evict_valid), 32'h0);

      step(1'b1, 1'b0, '0);
      ticks(20, 4'b0001);
      ticks(5, 4'b0010);
      ticks(6, 4'b0100);
      ticks(1, 4'b1000);
`ifndef LFU_AGING_EN
      chk("sat_idx", 32'(evict_idx), 32'h1);
      chk("sat_active", 32'(active), 32'hd);
`endif
      for (int k = 0; k < 40; k++)
         step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

      step(1'b1, 1'b1, 4'b1111);
      chk("mid_rst_active", 32'(active), 32'h0);
      chk("mid_rst_full", 32'(full), 32'h0);
      chk("mid_rst_ev", 32'(evict_valid), 32'h0);
      chk("mid_rst_idx", 32'(evict_idx), 32'h0);
      step(1'b0, 1'b1, 4'b0010);
      chk("post_rst_active", 32'(active), 32'h2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
